// File: rtl/lsu_subword_if.sv
// Core/memory-side bus of the sub-word load/store unit.
// The master side belongs to the core and memory; the slave side belongs to the LSU.
interface lsu_subword_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_subword.sv
// Byte/halfword/word load-store unit in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module lsu_subword #(
    parameter int unsigned ADDR_LIMIT = 1024
) (
    input logic          clk,
    input logic          rst_n,
    lsu_subword_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WR, RMW_RD, RMW_WR, RESP} state_e;

    state_e      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    function automatic logic req_bad(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        logic bad_f3;
        logic bad_align;
        if (wr) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        bad_align = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        return bad_f3 || bad_align || (a >= 32'(ADDR_LIMIT));
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_sub(input logic is_byte, input logic [1:0] lane,
                                              input logic [31:0] old, input logic [15:0] wd);
        logic [31:0] w;
        w = old;
        if (is_byte) w[{lane, 3'b000} +: 8]     = wd[7:0];
        else         w[{lane[1], 4'b0000} +: 16] = wd;
        return w;
    endfunction

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid) begin
                    req_ready_d  = 1'b0;
                    funct3_d     = bus.req_funct3;
                    lane_d       = bus.req_addr[1:0];
                    wdata_d      = bus.req_wdata[15:0];
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    if (req_bad(bus.req_write, bus.req_funct3, bus.req_addr)) begin
                        // Rejected accesses never touch memory.
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        if (!bus.req_write) begin
                            state_d    = LOAD;
                            mem_read_d = 1'b1;
                        end else if (bus.req_funct3[1:0] == 2'b10) begin
                            state_d     = WR;
                            mem_write_d = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                resp_rdata_d = load_ext(funct3_q, lane_q, bus.mem_rdata);
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RMW_RD: begin
                // Merge lands directly in the write-data register.
                mem_wdata_d = merge_sub(funct3_q[1:0] == 2'b00, lane_q, bus.mem_rdata, wdata_q);
                mem_write_d = 1'b1;
                state_d     = RMW_WR;
            end
            RMW_WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                resp_err_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            lane_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
